// File: rtl/pb_pkg.sv
// pb_pkg: shared constants and the event record for the pushbutton bank.
//
// Contents:
//   PB_N_CH          default number of button channels
//   PB_CNT_W         default debounce counter width
//   PB_DEBOUNCE_10MS default stable-cycle count (10 ms at 100 MHz)
//   PB_DEBOUNCE_SIM  short stable-cycle count for simulation
//   PB_ID_MAX_W      widest channel index the event record can carry
//   pb_evt_t         event record {id, multi, rel} as seen by the game FSM
package pb_pkg;

    localparam int PB_N_CH          = 4;
    localparam int PB_CNT_W         = 20;
    localparam int PB_DEBOUNCE_10MS = 1000000;
    localparam int PB_DEBOUNCE_SIM  = 4;
    localparam int PB_ID_MAX_W      = 8;

    typedef struct packed {
        logic [PB_ID_MAX_W-1:0] id;    // lowest channel index in the event
        logic                   multi; // two or more channels fired together
        logic                   rel;   // 1 = release event, 0 = press event
    } pb_evt_t;

endpackage

// File: rtl/pb_debounce_ch.sv
// pb_debounce_ch: one pushbutton channel.
//
// A two-flop synchroniser feeds a mismatch counter. The stable level only
// follows the synchronised input after it has disagreed with the level for
// DEBOUNCE_CYCLES consecutive counts; any agreement restarts the count, so
// shorter glitches are absorbed. A raw change held constant reaches `level`
// 2+DEBOUNCE_CYCLES edges after the first edge that samples it.
//
// Optional build macro: PB_RELEASE_EVT_EN adds the `fall` pulse output.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   raw    in   bouncy asynchronous button input, active-high
//   level  out  debounced stable level
//   rise   out  one-cycle pulse, high in the first cycle level reads 1
//   fall   out  one-cycle pulse, high in the first cycle level reads 0
//               (PB_RELEASE_EVT_EN only)
module pb_debounce_ch #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
`ifdef PB_RELEASE_EVT_EN
    ,
    output logic fall
`endif
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The count has already seen DEBOUNCE_CYCLES mismatches and the input
    // still disagrees: take the new level. The counter clears here, so it
    // never runs past TERM and never wraps.
    assign accept = (s != level) && (cnt == TERM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
`ifdef PB_RELEASE_EVT_EN
            fall  <= 1'b0;
`endif
        end else begin
            sync1 <= raw;
            s     <= sync1;
            rise  <= accept & s;
`ifdef PB_RELEASE_EVT_EN
            fall  <= accept & ~s;
`endif
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pb_debounce_bank.sv
// pb_debounce_bank: N-channel pushbutton front end for the memory game.
//
// Each channel is synchronised and debounced by pb_debounce_ch. Press
// pulses from all channels are arbitrated (lowest index wins, press_multi
// flags a tie) into a single-entry event register read by the game FSM.
//
// Optional build macro: PB_RELEASE_EVT_EN. When defined, debounced releases
// also produce events (press_rel=1); presses win over releases arriving in
// the same cycle, and dropped releases set overflow like dropped presses.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   btn_raw      in   [N_CH] raw button inputs, active-high
//   btn_level    out  [N_CH] debounced levels
//   btn_press    out  [N_CH] one-cycle debounced 0->1 pulses
//   press_valid  out  event register holds an unconsumed event
//   press_id     out  [ID_W] channel index of the held event
//   press_ready  in   consumer takes the event this cycle
//   press_multi  out  held event came from simultaneous channels
//   press_rel    out  held event is a release (PB_RELEASE_EVT_EN only)
//   overflow     out  sticky: an event was dropped while the register was full
//   ovf_clr      in   synchronous clear of overflow (a same-cycle drop wins)
module pb_debounce_bank
    import pb_pkg::*;
#(
    parameter int N_CH            = PB_N_CH,
    parameter int CNT_W           = PB_CNT_W,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_10MS,
    parameter int ID_W            = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic            press_valid,
    output logic [ID_W-1:0] press_id,
    input  logic            press_ready,
    output logic            press_multi,
`ifdef PB_RELEASE_EVT_EN
    output logic            press_rel,
`endif
    output logic            overflow,
    input  logic            ovf_clr
);

`ifdef PB_RELEASE_EVT_EN
    logic [N_CH-1:0] btn_release;
    logic            evt_rel;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pb_debounce_ch #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_press[i])
`ifdef PB_RELEASE_EVT_EN
            ,
            .fall (btn_release[i])
`endif
        );
    end

    // Select which set of pulses competes for the register this cycle.
    logic [N_CH-1:0] evt_bits;

    always_comb begin
        evt_bits = btn_press;
`ifdef PB_RELEASE_EVT_EN
        evt_rel = 1'b0;
        if (btn_press == '0) begin
            evt_bits = btn_release;
            evt_rel  = 1'b1;
        end
`endif
    end

    // Lowest set index and population count of the competing pulses.
    // ones is ID_W+1 bits wide, enough to hold N_CH.
    logic [ID_W-1:0] low_id;
    logic [ID_W:0]   ones;
    logic            evt_any;
    logic            evt_multi;

    always_comb begin
        low_id = '0;
        ones   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (evt_bits[i]) begin
                low_id = ID_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            ones = ones + {{ID_W{1'b0}}, evt_bits[i]};
        end
        evt_any   = |evt_bits;
        evt_multi = (ones[ID_W:1] != '0);
    end

    // Handshake: an event transfers on any edge where press_valid and
    // press_ready are both high. press_valid never depends on press_ready,
    // and press_id/press_multi/press_rel stay fixed while press_valid is
    // high and the event is not taken. A transfer frees the register on the
    // same edge, so a new event can load with no bubble.
    logic load;
    logic drop;

    assign load = evt_any && (!press_valid || press_ready);
    assign drop = evt_any && press_valid && !press_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_valid <= 1'b0;
            press_id    <= '0;
            press_multi <= 1'b0;
`ifdef PB_RELEASE_EVT_EN
            press_rel   <= 1'b0;
`endif
            overflow    <= 1'b0;
        end else begin
            if (load) begin
                press_valid <= 1'b1;
                press_id    <= low_id;
                press_multi <= evt_multi;
`ifdef PB_RELEASE_EVT_EN
                press_rel   <= evt_rel;
`endif
            end else if (press_valid && press_ready) begin
                // id/multi keep their last values after the transfer
                press_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_debounce_bank.sv
module tb_pb_debounce_bank;

    localparam int N    = 4;
    localparam int D    = 4;
    localparam int CW   = 8;
    localparam int ID_W = 2;
    localparam int EW   = ID_W + 2;   // {rel, multi, id}
`ifdef PB_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    btn_raw;
    logic [N-1:0]    btn_level;
    logic [N-1:0]    btn_press;
    logic            press_valid;
    logic [ID_W-1:0] press_id;
    logic            press_ready;
    logic            press_multi;
    logic            press_rel;
    logic            overflow;
    logic            ovf_clr;

    always #5 clk = ~clk;

    pb_debounce_bank #(
        .N_CH(N), .CNT_W(CW), .DEBOUNCE_CYCLES(D), .ID_W(ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .press_valid(press_valid),
        .press_id   (press_id),
        .press_ready(press_ready),
        .press_multi(press_multi),
`ifdef PB_RELEASE_EVT_EN
        .press_rel  (press_rel),
`endif
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

`ifndef PB_RELEASE_EVT_EN
    assign press_rel = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    // Debounce rule in terms of the raw samples: the level flips at an edge
    // when the raw values sampled 2..2+D edges earlier (D+1 samples) all
    // disagree with the current level. Pending events live in exp_q (at
    // most one entry); m_last remembers the most recently loaded event.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_last;
    logic [N-1:0]  m_level, m_press, m_relp;
    logic          m_ovf;
    logic [N-1:0]  hist [0:D+2];

    always @(posedge clk or negedge reset) begin
        logic [N-1:0]  bits, np, nr;
        logic          rel, drop, all_diff;
        logic [EW-1:0] ev;
        int            lo;
        if (!reset) begin
            exp_q.delete();
            m_last = '0; m_level = '0; m_press = '0; m_relp = '0; m_ovf = 1'b0;
            for (int j = 0; j <= D + 2; j++) hist[j] = '0;
        end else begin
            if (exp_q.size() != 0 && press_ready) void'(exp_q.pop_front());
            bits = m_press;
            rel  = 1'b0;
            drop = 1'b0;
            if (REL_EN && bits == '0) begin
                bits = m_relp;
                rel  = 1'b1;
            end
            if (bits != '0) begin
                lo = 0;
                for (int i = N - 1; i >= 0; i--) if (bits[i]) lo = i;
                ev = {rel, ($countones(bits) > 1), ID_W'(lo)};
                if (exp_q.size() == 0) begin
                    exp_q.push_back(ev);
                    m_last = ev;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;

            for (int j = D + 2; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = btn_raw;
            np = '0;
            nr = '0;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= D + 2; j++)
                    if (hist[j][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) np[i] = 1'b1;
                    else nr[i] = 1'b1;
                end
            end
            m_press = np;
            m_relp  = nr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic settle();
        btn_raw     = '0;
        press_ready = 1'b1;
        repeat (14) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr     = 1'b0;
        press_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = press_valid;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: press_valid got 0 exp 1 within 30 cycles", name);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn_raw = '1;
        repeat (3) @(negedge clk);
        tests++;
        if ({btn_level, btn_press, press_valid, press_id, press_multi, overflow} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got lvl=%b prs=%b v=%b id=%0d m=%b ovf=%b exp all 0",
                     btn_level, btn_press, press_valid, press_id, press_multi, overflow);
        end
        reset = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            tests++;
            if (btn_level !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
                fails++;
                $display("FAIL reset_latency_e%0d: btn_level got %b exp %b", k, btn_level,
                         (k == 6) ? 4'b1111 : 4'b0000);
            end
        end
        tests++;
        if (btn_press !== 4'b1111) begin
            fails++;
            $display("FAIL reset_press: btn_press got %b exp 1111", btn_press);
        end
        @(negedge clk);
        tests++;
        if ({press_valid, press_id, press_multi} !== {1'b1, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_event: got v=%b id=%0d m=%b exp v=1 id=0 m=1",
                     press_valid, press_id, press_multi);
        end
        settle();
    endtask

    task automatic test_bounce();
        int bad = 0, cnt = 0, first = -1;
        press_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            btn_raw[2] = ~k[0];
            @(negedge clk);
            if (btn_press !== '0) bad++;
        end
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (btn_press[2] === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (btn_press[3:0] & 4'b1011) bad++;
        end
        tests++;
        if (bad != 0 || cnt != 1 || first != 6 || btn_level[2] !== 1'b1) begin
            fails++;
            $display("FAIL bounce: got pulses=%0d first_edge=%0d stray=%0d lvl=%b exp 1 6 0 1",
                     cnt, first, bad, btn_level[2]);
        end
        settle();
    endtask

    task automatic test_glitch();
        int bad = 0;
        btn_raw[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn_raw[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL glitch: got %0d cycles with level/press set exp 0", bad);
        end
    endtask

    task automatic test_handshake();
        bit ok;
        press_ready = 1'b0;
        btn_raw[3]  = 1'b1;
        wait_valid("hs_first", ok);
        tests++;
        if (press_id !== 2'd3 || press_multi !== 1'b0) begin
            fails++;
            $display("FAIL hs_id3: got id=%0d m=%b exp id=3 m=0", press_id, press_multi);
        end
        btn_raw[1] = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if ({press_valid, press_id, overflow} !== {1'b1, 2'd3, 1'b1}) begin
            fails++;
            $display("FAIL hs_drop: got v=%b id=%0d ovf=%b exp v=1 id=3 ovf=1",
                     press_valid, press_id, overflow);
        end
        press_ready = 1'b1;
        @(negedge clk);
        press_ready = 1'b0;
        tests++;
        if ({press_valid, press_id, overflow} !== {1'b0, 2'd3, 1'b1}) begin
            fails++;
            $display("FAIL hs_accept: got v=%b id=%0d ovf=%b exp v=0 id=3 ovf=1",
                     press_valid, press_id, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL hs_ovf_clr: overflow got %b exp 0", overflow);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit seen = 1'b0;
        press_ready = 1'b0;
        btn_raw[0]  = 1'b1;
        wait_valid("b2b_first", ok);
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = btn_press[2];
        end
        press_ready = 1'b1;
        @(negedge clk);
        press_ready = 1'b0;
        tests++;
        if (!seen || {press_valid, press_id, overflow} !== {1'b1, 2'd2, 1'b0}) begin
            fails++;
            $display("FAIL b2b: got seen=%b v=%b id=%0d ovf=%b exp seen=1 v=1 id=2 ovf=0",
                     seen, press_valid, press_id, overflow);
        end
        settle();
    endtask

    task automatic test_release();
        bit seen = 1'b0;
        press_ready = 1'b1;
        btn_raw[1]  = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = btn_level[1];
        end
        @(negedge clk);
        tests++;
        if (!seen || {press_valid, press_id, press_rel} !== {1'b1, 2'd1, 1'b0}) begin
            fails++;
            $display("FAIL rel_press: got seen=%b v=%b id=%0d rel=%b exp 1 1 1 0",
                     seen, press_valid, press_id, press_rel);
        end
        btn_raw[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = !btn_level[1];
        end
        @(negedge clk);
        tests++;
        if (!seen || press_valid !== REL_EN ||
            (REL_EN && {press_id, press_rel} !== {2'd1, 1'b1})) begin
            fails++;
            $display("FAIL rel_release: got seen=%b v=%b id=%0d rel=%b exp 1 %b 1 1",
                     seen, press_valid, press_id, press_rel, REL_EN);
        end
        settle();
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            tests++;
            if (btn_level !== m_level || btn_press !== m_press) begin
                fails++;
                $display("FAIL rnd_level c%0d: got lvl=%b prs=%b exp lvl=%b prs=%b",
                         c, btn_level, btn_press, m_level, m_press);
            end
            tests++;
            if (press_valid !== (exp_q.size() != 0) || overflow !== m_ovf) begin
                fails++;
                $display("FAIL rnd_ctrl c%0d: got v=%b ovf=%b exp v=%b ovf=%b",
                         c, press_valid, overflow, exp_q.size() != 0, m_ovf);
            end
            if (exp_q.size() != 0) begin
                tests++;
                if ({press_rel, press_multi, press_id} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL rnd_event c%0d: got {rel,m,id}=%b exp %b",
                             c, {press_rel, press_multi, press_id}, exp_q[0]);
                end
            end else begin
                tests++;
                if ({press_multi, press_id} !== m_last[ID_W:0]) begin
                    fails++;
                    $display("FAIL rnd_hold c%0d: got {m,id}=%b exp %b",
                             c, {press_multi, press_id}, m_last[ID_W:0]);
                end
            end
            // stimulus for the next edge
            reset = (c < 300 || c > 302);
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i]    = $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            press_ready = ($urandom_range(0, 3) == 0);
            ovf_clr     = ($urandom_range(0, 15) == 0);
        end
        reset   = 1'b1;
        ovf_clr = 1'b0;
        settle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset       = 1'b1;
        btn_raw     = '0;
        press_ready = 1'b0;
        ovf_clr     = 1'b0;
        #2 reset = 1'b0;
        test_reset();
        test_bounce();
        test_glitch();
        test_handshake();
        test_back_to_back();
        test_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
